// File: rtl/neurocore_pkg.sv
// Shared definitions for the neurocore UART paths.
// Holds the default bit period (shared with the RX side), the packet header
// byte, the packet-FSM and byte-serialiser state encodings, and a helper
// that returns the number of bytes in a result packet.
package neurocore_pkg;

    // 10 MHz system clock / 115200 baud
    localparam int NC_CLKS_PER_BIT = 87;

    // First byte of every result packet
    localparam logic [7:0] NC_HEADER = 8'hA5;

    // Packet-level FSM
    typedef enum logic [2:0] {
        T_IDLE    = 3'd0,
        T_HDR     = 3'd1,
        T_PAYLOAD = 3'd2,
        T_CSUM    = 3'd3,
        T_FIN     = 3'd4
    } top_state_t;

    // Byte serialiser FSM
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_t;

    // Header + two bytes per 16-bit word + checksum
    function automatic int pkt_bytes(input int n_words);
        return 2 * n_words + 2;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, idle high.
// Ports:
//   CLK       system clock
//   RESET     synchronous active-high reset
//   tx_data   byte to send, taken when tx_valid && tx_ready
//   tx_valid  a byte is offered
//   tx_ready  serialiser can take a byte this cycle (idle, or last stop cycle)
//   TXD       registered serial output
module uart_tx_byte
    import neurocore_pkg::*;
#(
    parameter int CLKS_PER_BIT = NC_CLKS_PER_BIT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       TXD
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_reg;
    logic [7:0]       shift_reg;
    logic             txd_reg;

    logic bit_end;
    logic xfer;

    assign bit_end  = (cnt_reg == CNT_LAST);
    // Accepting a byte during the final stop cycle lets the next start bit
    // follow immediately with no idle gap.
    assign tx_ready = (state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end);
    assign xfer     = tx_valid && tx_ready;
    assign TXD      = txd_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            txd_reg   <= 1'b1;
        end else if (xfer) begin
            state_reg <= S_START;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= tx_data;
            txd_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_START: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DATA;
                        txd_reg   <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt_reg <= '0;
                        if (bit_reg == 3'd7) begin
                            state_reg <= S_STOP;
                            txd_reg   <= 1'b1;
                        end else begin
                            bit_reg   <= bit_reg + 3'd1;
                            txd_reg   <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    txd_reg   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/neurocore_result_tx.sv
// Result packet transmitter: snapshots the result vector on START and sends
// HEADER, each word high byte then low byte, then the XOR of the payload.
// Ports:
//   CLK     system clock
//   RESET   synchronous active-high reset, aborts any packet in flight
//   START   one-cycle request, accepted only when not busy
//   RESULT  N_WORDS x 16-bit result vector, word i at [16*i+15:16*i]
//   TXD     UART serial out (registered)
//   BUSY    packet in flight
//   DONE    one-cycle pulse after the last stop bit
module neurocore_result_tx
    import neurocore_pkg::*;
#(
    parameter int         CLKS_PER_BIT = NC_CLKS_PER_BIT,
    parameter int         N_WORDS      = 4,
    parameter int         WORD_W       = 16,
    parameter logic [7:0] HEADER       = NC_HEADER
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      START,
    input  logic [N_WORDS*WORD_W-1:0] RESULT,
    output logic                      TXD,
    output logic                      BUSY,
    output logic                      DONE
);

    localparam int PAY_BYTES = 2 * N_WORDS;
    localparam int IDX_W     = $clog2(pkt_bytes(N_WORDS));
    localparam int IDX_SLOTS = 1 << IDX_W;
    localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(PAY_BYTES);

    top_state_t                  state_reg;
    logic [N_WORDS*WORD_W-1:0]   snap_reg;
    logic [IDX_W-1:0]            idx_reg;   // next payload byte to hand over
    logic [7:0]                  csum_reg;

    logic [7:0] byte_slot [IDX_SLOTS];
    logic [7:0] cur_byte;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       xfer;

    // Payload bytes laid out in transmit order; slots past the payload read 0
    // so the index never has to be range-checked.
    generate
        for (genvar gi = 0; gi < IDX_SLOTS; gi++) begin : g_slot
            if (gi < PAY_BYTES) begin : g_pay
                assign byte_slot[gi] = snap_reg[WORD_W*(gi/2) + 8*(1 - (gi % 2)) +: 8];
            end else begin : g_pad
                assign byte_slot[gi] = 8'h00;
            end
        end
    endgenerate

    assign cur_byte = byte_slot[idx_reg];
    assign xfer     = tx_valid && tx_ready;

    // FIN behaves as idle for acceptance so a START coinciding with DONE
    // launches the next packet without a gap cycle.
    assign BUSY = (state_reg != T_IDLE) && (state_reg != T_FIN);
    assign DONE = (state_reg == T_FIN);

    // State names the byte currently on the wire; the offered byte is the
    // one that follows it.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = HEADER;
        case (state_reg)
            T_IDLE, T_FIN: begin
                tx_valid = START;
                tx_data  = HEADER;
            end
            T_HDR: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
            end
            T_PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = (idx_reg == IDX_CSUM) ? csum_reg : cur_byte;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = HEADER;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= T_IDLE;
            snap_reg  <= '0;
            idx_reg   <= '0;
            csum_reg  <= '0;
        end else begin
            case (state_reg)
                T_IDLE, T_FIN: begin
                    if (START) begin
                        snap_reg  <= RESULT;
                        idx_reg   <= '0;
                        csum_reg  <= '0;
                        state_reg <= T_HDR;
                    end else begin
                        state_reg <= T_IDLE;
                    end
                end
                T_HDR: begin
                    if (xfer) begin
                        csum_reg  <= csum_reg ^ cur_byte;
                        idx_reg   <= idx_reg + IDX_W'(1);
                        state_reg <= T_PAYLOAD;
                    end
                end
                T_PAYLOAD: begin
                    if (xfer) begin
                        if (idx_reg == IDX_CSUM) begin
                            state_reg <= T_CSUM;
                        end else begin
                            csum_reg <= csum_reg ^ cur_byte;
                            idx_reg  <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                T_CSUM: begin
                    if (tx_ready) begin
                        state_reg <= T_FIN;
                    end
                end
                default: state_reg <= T_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .CLK     (CLK),
        .RESET   (RESET),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .TXD     (TXD)
    );

endmodule

// File: tb/tb_neurocore_result_tx.sv
// Directed bench for neurocore_result_tx with CLKS_PER_BIT=4, N_WORDS=4.
// Each byte spans 40 cycles, a packet 400 cycles, DONE one cycle later.
module tb_neurocore_result_tx;

    localparam int CPB   = 4;
    localparam int NW    = 4;
    localparam int LOG_N = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NW*16-1:0] result = '0;
    logic          txd;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic       txd_log  [LOG_N];
    logic       busy_log [LOG_N];
    logic       done_log [LOG_N];
    logic [7:0] exp_bytes [10];

    localparam logic [NW*16-1:0] NOMINAL = {16'hFF00, 16'h0001, 16'hABCD, 16'h1234};

    neurocore_result_tx #(
        .CLKS_PER_BIT(CPB),
        .N_WORDS     (NW)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .START (start),
        .RESULT(result),
        .TXD   (txd),
        .BUSY  (busy),
        .DONE  (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Log index 0 is the START cycle t; index k is cycle t+k.
    task automatic capture(input int n, input int hold_until, input int poke_at, input int reset_at);
        txd_log[0]  = txd;
        busy_log[0] = busy;
        done_log[0] = done;
        for (int k = 1; k <= n; k++) begin
            tick();
            txd_log[k]  = txd;
            busy_log[k] = busy;
            done_log[k] = done;
            start = (k <= hold_until) || (k == poke_at);
            rst   = (k == reset_at);
            if (k == poke_at) result = '1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // Expected line level at offset c (1..400) into a packet of exp_bytes.
    function automatic logic exp_txd(input int c);
        int b;
        int slot;
        logic [7:0] v;
        b    = (c - 1) / 40;
        slot = ((c - 1) % 40) / 4;
        v    = exp_bytes[b];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return v[slot-1];
    endfunction

    function automatic int wave_errs(input int base);
        int e;
        e = 0;
        for (int c = 1; c <= 400; c++)
            if (txd_log[base + c] !== exp_txd(c)) e++;
        return e;
    endfunction

    // Samples each data bit near the middle of its bit period.
    function automatic logic [7:0] decode_byte(input int base, input int b);
        logic [7:0] d;
        for (int j = 0; j < 8; j++) d[j] = txd_log[base + 40*b + 6 + 4*j];
        return d;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int n;
        n = 0;
        for (int k = lo; k <= hi; k++) if (done_log[k] === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_txd_low(input int lo, input int hi);
        int n;
        n = 0;
        for (int k = lo; k <= hi; k++) if (txd_log[k] !== 1'b1) n++;
        return n;
    endfunction

    task automatic set_nominal();
        exp_bytes = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hBE};
        result    = NOMINAL;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; result = '0;
        repeat (3) tick();
        checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", txd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        tick();
        $display("test_reset: txd=%b busy=%b done=%b", txd, busy, done);
    endtask

    task automatic test_nominal();
        int e;
        int nb;
        logic [7:0] got;
        set_nominal();
        start = 1'b1;
        capture(410, 0, 0, 0);
        e = wave_errs(0);
        checks++; if (e !== 0) begin errors++; $display("FAIL nominal_wave mismatched_cycles=%0d exp=0", e); end
        for (int b = 0; b < 10; b++) begin
            got = decode_byte(0, b);
            checks++; if (got !== exp_bytes[b]) begin errors++; $display("FAIL nominal_byte%0d got=%02h exp=%02h", b, got, exp_bytes[b]); end
        end
        nb = 0;
        for (int k = 1; k <= 400; k++) if (busy_log[k] !== 1'b1) nb++;
        checks++; if (nb !== 0) begin errors++; $display("FAIL nominal_busy_hold low_cycles=%0d exp=0", nb); end
        checks++; if (busy_log[401] !== 1'b0) begin errors++; $display("FAIL nominal_busy_end got=%b exp=0", busy_log[401]); end
        checks++; if (done_log[401] !== 1'b1) begin errors++; $display("FAIL nominal_done_401 got=%b exp=1", done_log[401]); end
        checks++; if (count_done(0, 410) !== 1) begin errors++; $display("FAIL nominal_done_count got=%0d exp=1", count_done(0, 410)); end
        $display("test_nominal: bytes %02h %02h .. %02h done@401=%b", decode_byte(0, 0), decode_byte(0, 1), decode_byte(0, 9), done_log[401]);
    endtask

    task automatic test_bit_timing();
        int n;
        set_nominal();
        start = 1'b1;
        capture(410, 0, 0, 0);
        checks++; if (txd_log[0] !== 1'b1) begin errors++; $display("FAIL timing_idle_at_t got=%b exp=1", txd_log[0]); end
        n = 0;
        for (int k = 1; k <= 4; k++) if (txd_log[k] !== 1'b0) n++;
        checks++; if (n !== 0) begin errors++; $display("FAIL timing_start_bit high_cycles=%0d exp=0", n); end
        n = 0;
        for (int k = 5; k <= 8; k++) if (txd_log[k] !== 1'b1) n++;
        checks++; if (n !== 0) begin errors++; $display("FAIL timing_d0 low_cycles=%0d exp=0", n); end
        checks++; if (txd_log[9] !== 1'b0) begin errors++; $display("FAIL timing_d1 got=%b exp=0", txd_log[9]); end
        n = 0;
        for (int b = 1; b < 10; b++) if (txd_log[40*b] !== 1'b1 || txd_log[40*b + 1] !== 1'b0) n++;
        checks++; if (n !== 0) begin errors++; $display("FAIL timing_no_gap bad_boundaries=%0d exp=0", n); end
        $display("test_bit_timing: t..t+9 = %b%b%b%b%b%b%b%b%b%b", txd_log[0], txd_log[1], txd_log[2], txd_log[3],
                 txd_log[4], txd_log[5], txd_log[6], txd_log[7], txd_log[8], txd_log[9]);
    endtask

    task automatic test_all_zero();
        int e;
        exp_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        result = '0;
        start = 1'b1;
        capture(410, 0, 0, 0);
        e = wave_errs(0);
        checks++; if (e !== 0) begin errors++; $display("FAIL zero_wave mismatched_cycles=%0d exp=0", e); end
        checks++; if (decode_byte(0, 9) !== 8'h00) begin errors++; $display("FAIL zero_csum got=%02h exp=00", decode_byte(0, 9)); end
        checks++; if (done_log[401] !== 1'b1) begin errors++; $display("FAIL zero_done_401 got=%b exp=1", done_log[401]); end
        checks++; if (count_done(0, 410) !== 1) begin errors++; $display("FAIL zero_done_count got=%0d exp=1", count_done(0, 410)); end
        $display("test_all_zero: csum=%02h done@401=%b", decode_byte(0, 9), done_log[401]);
    endtask

    task automatic test_ignore_busy();
        int e;
        set_nominal();
        start = 1'b1;
        capture(450, 0, 50, 0);
        e = wave_errs(0);
        checks++; if (e !== 0) begin errors++; $display("FAIL ignore_wave mismatched_cycles=%0d exp=0", e); end
        checks++; if (count_done(0, 450) !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", count_done(0, 450)); end
        checks++; if (count_txd_low(401, 450) !== 0) begin errors++; $display("FAIL ignore_idle_after low_cycles=%0d exp=0", count_txd_low(401, 450)); end
        result = NOMINAL;
        $display("test_ignore_busy: done_pulses=%0d", count_done(0, 450));
    endtask

    task automatic test_reset_mid();
        int e;
        set_nominal();
        start = 1'b1;
        capture(200, 0, 0, 150);
        checks++; if (busy_log[150] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_log[150]); end
        checks++; if (txd_log[151] !== 1'b1) begin errors++; $display("FAIL rstmid_txd got=%b exp=1", txd_log[151]); end
        checks++; if (busy_log[151] !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_log[151]); end
        checks++; if (count_done(0, 200) !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", count_done(0, 200)); end
        checks++; if (count_txd_low(151, 200) !== 0) begin errors++; $display("FAIL rstmid_idle low_cycles=%0d exp=0", count_txd_low(151, 200)); end
        start = 1'b1;
        capture(410, 0, 0, 0);
        e = wave_errs(0);
        checks++; if (e !== 0) begin errors++; $display("FAIL rstmid_repeat_wave mismatched_cycles=%0d exp=0", e); end
        checks++; if (done_log[401] !== 1'b1) begin errors++; $display("FAIL rstmid_repeat_done got=%b exp=1", done_log[401]); end
        $display("test_reset_mid: txd@151=%b busy@151=%b repeat_done@401=%b", 1'b1 & txd_log[151], busy_log[151], done_log[401]);
    endtask

    task automatic test_back_to_back();
        int e0;
        int e1;
        set_nominal();
        start = 1'b1;
        capture(820, 401, 0, 0);
        e0 = wave_errs(0);
        e1 = wave_errs(401);
        checks++; if (e0 !== 0) begin errors++; $display("FAIL b2b_first_wave mismatched_cycles=%0d exp=0", e0); end
        checks++; if (e1 !== 0) begin errors++; $display("FAIL b2b_second_wave mismatched_cycles=%0d exp=0", e1); end
        checks++; if (txd_log[401] !== 1'b1 || txd_log[402] !== 1'b0) begin
            errors++; $display("FAIL b2b_start_edge got=%b%b exp=10", txd_log[401], txd_log[402]);
        end
        checks++; if (busy_log[402] !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy_log[402]); end
        checks++; if (done_log[401] !== 1'b1 || done_log[802] !== 1'b1) begin
            errors++; $display("FAIL b2b_done_times got=%b,%b exp=1,1", done_log[401], done_log[802]);
        end
        checks++; if (count_done(0, 820) !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", count_done(0, 820)); end
        $display("test_back_to_back: done@401=%b done@802=%b pulses=%0d", done_log[401], done_log[802], count_done(0, 820));
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bit_timing();
        test_all_zero();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neurocore_result_tx.md
Name: neurocore_result_tx

Overview:
UART transmit-side framer for the neurocore result path. When the multiply core signals completion, it snapshots the result vector and serialises it on TXD as a framed packet: header, payload bytes, then an XOR checksum. It is the outbound counterpart of the chip's UART command receiver and drives the TXD pin directly. Line format is 8N1, LSB first, idle high.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal range is >= 2.
N_WORDS, 4, number of result words per packet; legal range is 1..16.
WORD_W, 16, result word width; fixed at 16 (two bytes per word).
HEADER, 8'hA5, first byte of every packet.

Ports:
CLK  input  1  system clock.
RESET  input  1  synchronous reset, active-high.
START  input  1  single-cycle request, driven from MULT_DONE; sampled only in IDLE.
RESULT  input  N_WORDS*WORD_W  result vector; word i = RESULT[16*i+15:16*i]; sampled on the accepted START edge.
TXD  output  1  UART serial out, registered.
BUSY  output  1  high while a packet is in flight.
DONE  output  1  one-cycle pulse after the last stop bit of a packet.

Behaviour:
- One clock, CLK. RESET is synchronous and active-high.
- Reset values: TXD=1, BUSY=0, DONE=0. Internal FSM goes to IDLE, counters and the snapshot register go to 0.
- RESET has priority over all other inputs. Asserting it mid-packet aborts the packet: TXD=1 on the next edge, no DONE pulse, no partial retry.
- Packet byte order: HEADER, then for i=0..N_WORDS-1 send word i high byte followed by low byte, then CSUM.
  - CSUM = XOR of all payload bytes; HEADER is excluded.
  - Total bytes = 2*N_WORDS+2, which is 10 at the default.
- Byte framing: start bit (0), then d0..d7 LSB first, then stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- Bytes go back-to-back with no idle gap; the next start bit follows the previous stop bit's last cycle.
- START acceptance: START=1 in IDLE at edge t latches RESULT into the snapshot register.
  - BUSY=1 and TXD=0 from t+1.
  - RESULT changes after t have no effect on the packet in flight.
- START while BUSY=1 is ignored and not queued.
- Completion: the last stop-bit cycle ends at t + 10*CLKS_PER_BIT*(2*N_WORDS+2). In the following cycle DONE=1, BUSY=0 and the FSM is in IDLE.
- START coincident with DONE is accepted, giving back-to-back packets; TXD goes low in the cycle after DONE.
- Top FSM: IDLE -> HDR -> PAYLOAD (byte index 0..2*N_WORDS-1) -> CSUM -> FIN -> IDLE.
  - FIN lasts one cycle and asserts DONE.
  - The checksum accumulates as each payload byte is handed to the byte serialiser.
- Byte serialiser FSM: S_IDLE -> S_START -> S_DATA (bit index 0..7) -> S_STOP -> S_IDLE.
  - Handshake is tx_valid/tx_ready. A byte transfers when both are high.
  - tx_ready is high in S_IDLE and in the last cycle of S_STOP, which is what makes back-to-back bytes possible.
- Counter widths: bit counter is clog2(CLKS_PER_BIT); byte index is clog2(2*N_WORDS+2). Neither counter may wrap within a packet.

Decomposition:
- Shared package neurocore_pkg holds:
  - the default CLKS_PER_BIT constant, shared with the RX side;
  - the HEADER constant;
  - the top-FSM and serialiser state enums;
  - a function for the packet byte count.
- Sub-module uart_tx_byte(CLK, RESET, tx_data[7:0], tx_valid, tx_ready, TXD) contains the bit timer and shift register.
- The top level contains the packet FSM, snapshot register and checksum.

Test Plan:
(All scenarios use CLKS_PER_BIT=4 and N_WORDS=4.)
- Nominal packet: RESULT words {0x1234, 0xABCD, 0x0001, 0xFF00}, START at t.
  - TXD decodes to A5 12 34 AB CD 00 01 FF 00 BE.
  - BUSY=1 over t+1..t+400; DONE pulses at t+401 only.
- Bit timing: same packet.
  - Start bit is low for exactly 4 cycles starting at t+1.
  - The first data bit of A5 (LSB=1) is high at t+5..t+8.
  - No idle gap between the stop bit of one byte and the start bit of the next.
- All-zero RESULT: TXD decodes to A5 00 00 00 00 00 00 00 00 00; DONE at t+401.
- Ignore while busy: pulse START again at t+50 and change RESULT to all-ones.
  - The packet in flight is unchanged.
  - Exactly one DONE pulse, and TXD=1 after t+400.
- Reset mid-packet: assert RESET at t+150 for 1 cycle.
  - TXD=1, BUSY=0 on the next edge; no DONE.
  - A new START then produces a full, correct 400-cycle packet.
- Back-to-back: START held at 1 across DONE.
  - The second packet's start bit begins at t+402.
  - Two DONE pulses, exactly 401 cycles apart.
